// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: op field layout, access sizes,
// fault causes and the FSM state encoding.
package mem_pkg;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_INV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_INVALID  = 2'b10,
        FC_RANGE    = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_if.sv
// Request/response channel bundle between the execute stage and the load/store unit.
interface mem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       rdata;
    logic              fault;
    logic [1:0]        fault_cause;

    modport master (
        output req_valid, op, addr, wdata, resp_ready,
        input  req_ready, resp_valid, rdata, fault, fault_cause
    );

    modport slave (
        input  req_valid, op, addr, wdata, resp_ready,
        output req_ready, resp_valid, rdata, fault, fault_cause
    );
endinterface

// File: rtl/mem_bank.sv
// One byte lane of data storage: synchronous write, address taken
// combinationally and read data registered on the same edge.
module mem_bank #(
    parameter int  ENTRIES = 64,
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_unit.sv
// Handshaked load/store unit: four byte-lane banks, fault classification,
// sign/zero extension and an IDLE/WAIT/RESP controller with wait states.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_STATES = 0
) (
    input logic   clk,
    input logic   reset,
    mem_if.slave  bus
);
    localparam int ENTRIES = DEPTH_BYTES / 4;
    localparam int BANK_AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int IDX_W   = $clog2(DEPTH_BYTES);

    state_e               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [ADDR_W-1:0]    addr_in;
    logic [1:0]           size_in;
    logic [1:0]           lane_in;
    logic                 accept;
    fault_e               cause_in;
    logic [3:0]           be;
    logic [31:0]          wdata_rot;
    logic [BANK_AW-1:0]   bank_addr;
    logic [3:0][7:0]      bank_q;
    logic [31:0]          rd_shift;

    logic [3:0]           op_p0;
    logic [1:0]           lane_p0;
    logic [BANK_AW-1:0]   word_p0;
    fault_e               cause_p0;

    function automatic fault_e classify(input logic [3:0] op, input logic [1:0] lo,
                                        input logic hi_set);
        logic [1:0] sz;
        sz = op[OP_SZ_HI:OP_SZ_LO];
        if (sz == SZ_INV || (op[OP_STORE] && op[OP_UNS])) return FC_INVALID;
        if ((sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00)) return FC_MISALIGN;
        if (hi_set) return FC_RANGE;
        return FC_NONE;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            SZ_B:    return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_H:    return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign addr_in   = bus.addr;
    assign size_in   = bus.op[OP_SZ_HI:OP_SZ_LO];
    assign lane_in   = addr_in[1:0];
    assign accept    = (state == ST_IDLE) && bus.req_valid;
    // Out-of-range means any address bit above the storage index is set; no aliasing.
    assign cause_in  = classify(bus.op, lane_in, |(addr_in >> IDX_W));
    assign wdata_rot = bus.wdata << {lane_in, 3'b000};
    // Banks keep reading the latched word after accept so the response stays stable.
    assign bank_addr = (state == ST_IDLE) ? BANK_AW'(addr_in >> 2) : word_p0;

    always_comb begin
        be = 4'b0000;
        if (accept && bus.op[OP_STORE] && cause_in == FC_NONE) begin
            case (size_in)
                SZ_B:    be = 4'b0001 << lane_in;
                SZ_H:    be = 4'b0011 << lane_in;
                SZ_W:    be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bank
        mem_bank #(.ENTRIES(ENTRIES)) u_bank (
            .clk   (clk),
            .we    (be[i]),
            .addr  (bank_addr),
            .wdata (wdata_rot[8*i +: 8]),
            .rdata (bank_q[i])
        );
    end

    // Stage p0: request captured in the accept cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= bus.op;
            lane_p0 <= lane_in;
            word_p0 <= BANK_AW'(addr_in >> 2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            cause_p0 <= FC_NONE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cause_p0 <= cause_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_RESP;
                    end else begin
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: response formed from registered bank data and latched request
    assign rd_shift        = bank_q >> {lane_p0, 3'b000};
    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.resp_valid  = (state == ST_RESP);
    assign bus.fault       = (cause_p0 != FC_NONE);
    assign bus.fault_cause = cause_p0;
    assign bus.rdata       = (state == ST_RESP && cause_p0 == FC_NONE && !op_p0[OP_STORE])
                             ? extend(rd_shift, op_p0[OP_SZ_HI:OP_SZ_LO], op_p0[OP_UNS])
                             : 32'd0;
endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_mem_unit;
    localparam int DEPTH = 256;
    localparam int WS    = 3;
    localparam int NDIR  = 26;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [1:0]  cause;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    logic [7:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    mem_if #(.ADDR_W(32)) bus();

    mem_unit #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: apply the access rules directly to a byte array.
    function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] exp_rd,
                                  output logic [1:0] exp_c);
        int size;
        int nb;
        logic [31:0] v;
        size   = int'(op[1:0]);
        exp_rd = 32'd0;
        if (size == 3 || (op[3] && op[2])) exp_c = 2'd2;
        else if (addr % (32'd1 << size) != 0) exp_c = 2'd1;
        else if (addr >= DEPTH) exp_c = 2'd3;
        else begin
            exp_c = 2'd0;
            nb    = 1 << size;
            if (op[3]) begin
                for (int i = 0; i < nb; i++) model_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | ({24'b0, model_mem[addr + i]} << (8*i));
                if (!op[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 1);
                exp_rd = v;
            end
        end
    endfunction

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd, output logic f,
                        output logic [1:0] c, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.addr      = addr;
        bus.wdata     = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 50);
        rd = bus.rdata;
        f  = bus.fault;
        c  = bus.fault_cause;
        repeat (hold) @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        checks++;
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
        checks++;
        if (bus.rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        checks++;
        if (bus.fault !== 1'b0 || bus.fault_cause !== 2'd0) begin
            fails++; $display("FAIL reset_fault got=%b/%b want=0/00", bus.fault, bus.fault_cause);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] rd, er, w;
        logic f;
        logic [1:0] c, ec;
        int lat;
        for (int i = 0; i < DEPTH / 4; i++) begin
            w = $urandom;
            model(4'b1010, 32'(4*i), w, er, ec);
            send(4'b1010, 32'(4*i), w, 0, rd, f, c, lat);
            checks++;
            if (rd !== er || f !== 1'b0 || c !== ec || lat !== WS + 1) begin
                fails++;
                $display("FAIL fill[%0d] rdata=%h fault=%b cause=%b lat=%0d want rdata=%h cause=%b lat=%0d",
                         i, rd, f, c, lat, er, ec, WS + 1);
            end
        end
    endtask

    task automatic test_directed();
        vec_t tbl [NDIR];
        logic [31:0] rd, er;
        logic f;
        logic [1:0] c, ec;
        int lat;
        tbl = '{
            '{4'b1010, 32'h10,       32'h8765_4321, 32'h0,          2'd0},
            '{4'b0010, 32'h10,       32'h0,         32'h8765_4321,  2'd0},
            '{4'b0000, 32'h13,       32'h0,         32'hFFFF_FF87,  2'd0},
            '{4'b0100, 32'h13,       32'h0,         32'h0000_0087,  2'd0},
            '{4'b0001, 32'h12,       32'h0,         32'hFFFF_8765,  2'd0},
            '{4'b0101, 32'h12,       32'h0,         32'h0000_8765,  2'd0},
            '{4'b0110, 32'h10,       32'h0,         32'h8765_4321,  2'd0},
            '{4'b0001, 32'h21,       32'h0,         32'h0,          2'd1},
            '{4'b1010, 32'h20,       32'h1122_3344, 32'h0,          2'd0},
            '{4'b1010, 32'h22,       32'hDEAD_BEEF, 32'h0,          2'd1},
            '{4'b0010, 32'h20,       32'h0,         32'h1122_3344,  2'd0},
            '{4'b0011, 32'h20,       32'h0,         32'h0,          2'd2},
            '{4'b1100, 32'h20,       32'hAAAA_AAAA, 32'h0,          2'd2},
            '{4'b0010, 32'h20,       32'h0,         32'h1122_3344,  2'd0},
            '{4'b0011, 32'h101,      32'h0,         32'h0,          2'd2},
            '{4'b1000, 32'hFF,       32'h0000_003C, 32'h0,          2'd0},
            '{4'b0000, 32'h100,      32'h0,         32'h0,          2'd3},
            '{4'b1000, 32'h1FF,      32'h0000_005A, 32'h0,          2'd3},
            '{4'b0100, 32'hFF,       32'h0,         32'h0000_003C,  2'd0},
            '{4'b0010, 32'h8000_0010, 32'h0,        32'h0,          2'd3},
            '{4'b1010, 32'h30,       32'h0102_0304, 32'h0,          2'd0},
            '{4'b1001, 32'h32,       32'h0000_CAFE, 32'h0,          2'd0},
            '{4'b1000, 32'h31,       32'h0000_0077, 32'h0,          2'd0},
            '{4'b0010, 32'h30,       32'h0,         32'hCAFE_7704,  2'd0},
            '{4'b0001, 32'h30,       32'h0,         32'h0000_7704,  2'd0},
            '{4'b0001, 32'h32,       32'h0,         32'hFFFF_CAFE,  2'd0}
        };
        for (int i = 0; i < NDIR; i++) begin
            model(tbl[i].op, tbl[i].addr, tbl[i].wdata, er, ec);
            send(tbl[i].op, tbl[i].addr, tbl[i].wdata, i % 3, rd, f, c, lat);
            checks++;
            if (rd !== tbl[i].rd || c !== tbl[i].cause || f !== (tbl[i].cause != 2'd0)) begin
                fails++;
                $display("FAIL directed[%0d] rdata=%h fault=%b cause=%b want rdata=%h cause=%b",
                         i, rd, f, c, tbl[i].rd, tbl[i].cause);
            end
        end
    endtask

    task automatic test_timing();
        logic [31:0] er, er2;
        logic [1:0] ec, ec2;
        int lat;
        model(4'b0010, 32'h10, 32'h0, er, ec);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op        = 4'b0010;
        bus.addr      = 32'h10;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.resp_valid) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL wait_req_ready got=%b want=0", bus.req_ready); end
            end
        end while (!bus.resp_valid && lat < 50);
        checks++;
        if (lat !== WS + 1) begin fails++; $display("FAIL latency got=%0d want=%0d", lat, WS + 1); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rdata !== er || bus.fault !== 1'b0) begin
                fails++;
                $display("FAIL stall[%0d] valid=%b ready=%b rdata=%h fault=%b want 1/0/%h/0",
                         k, bus.resp_valid, bus.req_ready, bus.rdata, bus.fault, er);
            end
            @(negedge clk);
        end
        model(4'b0000, 32'h13, 32'h0, er2, ec2);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.op         = 4'b0000;
        bus.addr       = 32'h13;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL release valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 50);
        checks++;
        if (lat !== WS + 1 || bus.rdata !== er2 || bus.fault_cause !== ec2) begin
            fails++;
            $display("FAIL back_to_back lat=%0d rdata=%h cause=%b want lat=%0d rdata=%h cause=%b",
                     lat, bus.rdata, bus.fault_cause, WS + 1, er2, ec2);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, er, a, w;
        logic [3:0] op;
        logic f;
        logic [1:0] c, ec;
        int lat, r;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            w  = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, DEPTH - 1));
            else if (r < 9) a = 32'($urandom_range(DEPTH, DEPTH + 60));
            else a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            model(op, a, w, er, ec);
            send(op, a, w, $urandom_range(0, 2), rd, f, c, lat);
            checks++;
            if (rd !== er || c !== ec || f !== (ec != 2'd0) || lat !== WS + 1) begin
                fails++;
                $display("FAIL random[%0d] op=%b addr=%h rdata=%h fault=%b cause=%b lat=%0d want rdata=%h cause=%b",
                         i, op, a, rd, f, c, lat, er, ec);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er;
        logic f;
        logic [1:0] c, ec;
        int lat;
        model(4'b1000, 32'h41, 32'h0000_005E, er, ec);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op        = 4'b1000;
        bus.addr      = 32'h41;
        bus.wdata     = 32'h0000_005E;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL midreset_resp_valid got=%b want=0", bus.resp_valid); end
        checks++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL midreset_req_ready got=%b want=1", bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        model(4'b0100, 32'h41, 32'h0, er, ec);
        send(4'b0100, 32'h41, 32'h0, 0, rd, f, c, lat);
        checks++;
        if (rd !== er || rd !== 32'h0000_005E || c !== 2'd0) begin
            fails++; $display("FAIL midreset_readback rdata=%h cause=%b want rdata=0000005e cause=00", rd, c);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.op         = 4'd0;
        bus.addr       = 32'd0;
        bus.wdata      = 32'd0;
        test_reset();
        test_fill();
        test_directed();
        test_timing();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
